// File: rtl/exec_muldiv_ctrl_if.sv
// exec_muldiv_ctrl_if: request/response bundle between the execute stage and
// the iterative RV32M multiply/divide sequencer.
//   flush, start, funct3, srcA, srcB, rdAddrE : execute -> sequencer
//   stall, busy, done, result, rdAddr         : sequencer -> execute/hazard/writeback
// Modports: master = execute side, slave = sequencer.
interface exec_muldiv_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [4:0]      rdAddrE;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rdAddr;

    modport master (
        output flush, start, funct3, srcA, srcB, rdAddrE,
        input  stall, busy, done, result, rdAddr
    );

    modport slave (
        input  flush, start, funct3, srcA, srcB, rdAddrE,
        output stall, busy, done, result, rdAddr
    );
endinterface

// File: rtl/exec_muldiv_ctrl.sv
// exec_muldiv_ctrl: iterative RV32M multiply/divide sequencer beside the
// execute-stage ALU. Accepts one M-op, holds the front of the pipeline with
// stall while a shift-add multiply or restoring divide runs for XLEN cycles,
// then presents result/rdAddr for one cycle with done.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - exec_muldiv_ctrl_if.slave (flush/start/funct3/srcA/srcB/rdAddrE in,
//          stall/busy/done/result/rdAddr out; stall is combinational)
// Configuration macro: FAST_MUL_EN - when defined, multiplies complete with a
// single-cycle XLENxXLEN product; divides stay iterative.
module exec_muldiv_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    exec_muldiv_ctrl_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      op;
    logic            neg;
    logic [4:0]      rd_q;
    // opnd: multiplicand (mul) or divisor (div).
    // acc_hi/acc_lo: product high/low (mul) or remainder/quotient-dividend (div).
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;

    // Accept-time decode: operand magnitudes, sign flag and special cases
    logic            a_signed, b_signed, sa, sb, neg_n;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            is_div, div0, ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed    = 1'b0;
        b_signed    = 1'b0;
        special_res = '0;
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         begin a_signed = 1'b1; end
            default:                        ;
        endcase
        sa     = a_signed & bus.srcA[XLEN-1];
        sb     = b_signed & bus.srcB[XLEN-1];
        a_abs  = sa ? (XLEN'(0) - bus.srcA) : bus.srcA;
        b_abs  = sb ? (XLEN'(0) - bus.srcB) : bus.srcB;
        // remainder follows the dividend sign, everything else the product/quotient sign
        neg_n  = (bus.funct3[2] & bus.funct3[1]) ? sa : (sa ^ sb);
        is_div = bus.funct3[2];
        div0   = is_div && (bus.srcB == '0);
        ovf    = is_div && !bus.funct3[0]
               && (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.srcB == '1);
        special = div0 | ovf;
        if (div0)
            special_res = bus.funct3[1] ? bus.srcA : '1;
        else if (ovf)
            special_res = bus.funct3[1] ? '0 : bus.srcA;
    end

`ifdef FAST_MUL_EN
    // Single-cycle product on magnitudes, sign applied afterwards
    logic [PW-1:0]   fast_prod, fast_prod_s;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        fast_prod   = PW'(a_abs) * PW'(b_abs);
        fast_prod_s = neg_n ? (PW'(0) - fast_prod) : fast_prod;
        fast_res    = (bus.funct3[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0]
                                                 : fast_prod_s[PW-1:XLEN];
    end
`endif

    // One iteration step for each datapath, plus the final signed result
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_n, div_lo_n;
    logic [PW-1:0]   prod, prod_s;
    logic [XLEN-1:0] mul_res, div_sel, div_res, fin_res;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi_n  = mul_sum[XLEN:1];
        mul_lo_n  = {mul_sum[0], acc_lo[XLEN-1:1]};

        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_hi_n  = div_ge ? XLEN'(div_shift - {1'b0, opnd}) : div_shift[XLEN-1:0];
        div_lo_n  = {acc_lo[XLEN-2:0], div_ge};

        prod      = {mul_hi_n, mul_lo_n};
        prod_s    = neg ? (PW'(0) - prod) : prod;
        mul_res   = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
        div_sel   = op[1] ? div_hi_n : div_lo_n;
        div_res   = neg ? (XLEN'(0) - div_sel) : div_sel;
        fin_res   = op[2] ? div_res : mul_res;
    end

    // Hold F/D/E in the accept cycle and for the whole iteration phase
    assign bus.stall = (bus.start && (state == S_IDLE)) || (state == S_CALC);

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op         <= '0;
            neg        <= 1'b0;
            rd_q       <= '0;
            opnd       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.rdAddr <= '0;
        end else if (bus.flush) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op   <= bus.funct3;
                        neg  <= neg_n;
                        rd_q <= bus.rdAddrE;
                        cnt  <= '0;
                        if (special) begin
                            state      <= S_DONE;
                            bus.busy   <= 1'b1;
                            bus.done   <= 1'b1;
                            bus.result <= special_res;
                            bus.rdAddr <= bus.rdAddrE;
                        end
`ifdef FAST_MUL_EN
                        else if (!bus.funct3[2]) begin
                            state      <= S_DONE;
                            bus.busy   <= 1'b1;
                            bus.done   <= 1'b1;
                            bus.result <= fast_res;
                            bus.rdAddr <= bus.rdAddrE;
                        end
`endif
                        else begin
                            state    <= S_CALC;
                            bus.busy <= 1'b1;
                            opnd     <= bus.funct3[2] ? b_abs : a_abs;
                            acc_hi   <= '0;
                            acc_lo   <= bus.funct3[2] ? a_abs : b_abs;
                        end
                    end
                end
                S_CALC: begin
                    acc_hi <= op[2] ? div_hi_n : mul_hi_n;
                    acc_lo <= op[2] ? div_lo_n : mul_lo_n;
                    cnt    <= cnt + CNT_W'(1);
                    // last iteration: the sign fix-up is folded into the same edge
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state      <= S_DONE;
                        bus.done   <= 1'b1;
                        bus.result <= fin_res;
                        bus.rdAddr <= rd_q;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule
